// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states, ACC source
// select encodings and instruction field positions.
package bip_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM  = 2'd0;
    localparam logic [1:0] SELA_ALU  = 2'd1;
    localparam logic [1:0] SELA_HOLD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_e;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: EXEC-cycle strobe pattern plus the two
// sequencing hints (memory operand needed, halt) consumed by the FSM.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] i_opcode,
    output logic [1:0] o_sel_a,
    output logic       o_sel_b,
    output logic       o_op,
    output logic       o_wr_acc,
    output logic       o_wr_ram,
    output logic       o_needs_mem,
    output logic       o_is_halt
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        o_sel_a     = SELA_HOLD;
        o_sel_b     = 1'b0;
        o_op        = 1'b0;
        o_wr_acc    = 1'b0;
        o_wr_ram    = 1'b0;
        o_needs_mem = 1'b0;
        o_is_halt   = 1'b0;
        case (i_opcode)
            OPC_HLT:  o_is_halt = 1'b1;
            OPC_STO:  o_wr_ram  = 1'b1;
            OPC_LD: begin
                o_sel_a     = SELA_MEM;
                o_wr_acc    = 1'b1;
                o_needs_mem = 1'b1;
            end
            OPC_LDI: begin
                o_sel_a  = SELA_ALU;
                o_sel_b  = 1'b1;
                o_wr_acc = 1'b1;
            end
            OPC_ADD: begin
                o_sel_a     = SELA_ALU;
                o_wr_acc    = 1'b1;
                o_needs_mem = 1'b1;
            end
            OPC_ADDI: begin
                o_sel_a  = SELA_ALU;
                o_sel_b  = 1'b1;
                o_wr_acc = 1'b1;
            end
            OPC_SUB: begin
                o_sel_a     = SELA_ALU;
                o_op        = 1'b1;
                o_wr_acc    = 1'b1;
                o_needs_mem = 1'b1;
            end
            OPC_SUBI: begin
                o_sel_a  = SELA_ALU;
                o_sel_b  = 1'b1;
                o_op     = 1'b1;
                o_wr_acc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control_fsm.sv
// Multi-cycle BIP control unit: owns PC and IR and sequences the datapath
// strobes as registered outputs; FETCH -> DECODE -> [MEM] -> EXEC.
module bip_control_fsm
    import bip_pkg::*;
#(
    parameter int len_data   = 16,
    parameter int len_opcode = 5,
    parameter int len_addr   = 11,
    parameter int len_cycles = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [len_data-1:0]   instruction,
    output logic [len_addr-1:0]   pc,
    output logic [len_addr-1:0]   operand,
    output logic [1:0]            SelA,
    output logic                  SelB,
    output logic                  Op,
    output logic                  WrAcc,
    output logic                  RdRam,
    output logic                  WrRam,
    output logic                  halted,
    output logic [len_cycles-1:0] cycle_count
);

    state_e                r_state;
    logic [len_addr-1:0]   r_pc;
    logic [len_data-1:0]   r_ir;
    logic [len_cycles-1:0] r_cycles;
    logic [1:0]            r_sel_a;
    logic                  r_sel_b, r_op, r_wr_acc, r_rd_ram, r_wr_ram, r_halted;

    state_e                w_state_nxt;
    logic [len_addr-1:0]   w_pc_nxt;
    logic [len_data-1:0]   w_ir_nxt;
    logic [len_cycles-1:0] w_cycles_nxt;
    logic [1:0]            w_sel_a_nxt;
    logic                  w_sel_b_nxt, w_op_nxt, w_wr_acc_nxt, w_rd_ram_nxt;
    logic                  w_wr_ram_nxt, w_halted_nxt;

    logic [len_opcode-1:0] w_opcode;
    logic [1:0]            w_dec_sel_a;
    logic                  w_dec_sel_b, w_dec_op, w_dec_wr_acc, w_dec_wr_ram;
    logic                  w_dec_needs_mem, w_dec_is_halt;
    logic                  w_busy;

    // In DECODE the IR is still being loaded, so decode straight from memory.
    assign w_opcode = (r_state == S_DECODE) ? instruction[OPC_MSB:OPC_LSB]
                                            : r_ir[OPC_MSB:OPC_LSB];
    assign w_busy   = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_MEM)   || (r_state == S_EXEC);

    bip_decoder u_decoder (
        .i_opcode   (w_opcode),
        .o_sel_a    (w_dec_sel_a),
        .o_sel_b    (w_dec_sel_b),
        .o_op       (w_dec_op),
        .o_wr_acc   (w_dec_wr_acc),
        .o_wr_ram   (w_dec_wr_ram),
        .o_needs_mem(w_dec_needs_mem),
        .o_is_halt  (w_dec_is_halt)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_cycles_nxt = r_cycles;
        w_sel_a_nxt  = SELA_HOLD;
        w_sel_b_nxt  = 1'b0;
        w_op_nxt     = 1'b0;
        w_wr_acc_nxt = 1'b0;
        w_wr_ram_nxt = 1'b0;

        if (w_busy && (r_cycles != '1))
            w_cycles_nxt = r_cycles + 1'b1;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_state_nxt  = S_FETCH;
                    w_pc_nxt     = '0;
                    w_cycles_nxt = '0;
                end
            end
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: begin
                w_ir_nxt = instruction;
                if (w_dec_is_halt)        w_state_nxt = S_HALT;
                else if (w_dec_needs_mem) w_state_nxt = S_MEM;
                else                      w_state_nxt = S_EXEC;
            end
            S_MEM:    w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = S_FETCH;
            end
            default:  w_state_nxt = S_IDLE;
        endcase

        // Strobes are loaded on entry so they line up exactly with their state.
        w_halted_nxt = (w_state_nxt == S_HALT);
        w_rd_ram_nxt = (w_state_nxt == S_MEM);
        if (w_state_nxt == S_EXEC) begin
            w_sel_a_nxt  = w_dec_sel_a;
            w_sel_b_nxt  = w_dec_sel_b;
            w_op_nxt     = w_dec_op;
            w_wr_acc_nxt = w_dec_wr_acc;
            w_wr_ram_nxt = w_dec_wr_ram;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_cycles <= '0;
            r_sel_a  <= SELA_HOLD;
            r_sel_b  <= 1'b0;
            r_op     <= 1'b0;
            r_wr_acc <= 1'b0;
            r_rd_ram <= 1'b0;
            r_wr_ram <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_cycles <= w_cycles_nxt;
            r_sel_a  <= w_sel_a_nxt;
            r_sel_b  <= w_sel_b_nxt;
            r_op     <= w_op_nxt;
            r_wr_acc <= w_wr_acc_nxt;
            r_rd_ram <= w_rd_ram_nxt;
            r_wr_ram <= w_wr_ram_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    assign pc          = r_pc;
    assign operand     = r_ir[len_addr-1:0];
    assign SelA        = r_sel_a;
    assign SelB        = r_sel_b;
    assign Op          = r_op;
    assign WrAcc       = r_wr_acc;
    assign RdRam       = r_rd_ram;
    assign WrRam       = r_wr_ram;
    assign halted      = r_halted;
    assign cycle_count = r_cycles;

endmodule
